control_sequencer: RTL

//  Hardwired control unit: the real driver of the DataPath control inputs, replacing bench-driven strobes.

---
 rtl/control_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, class decode of IR[31:27], per-class execute T3-T7.
// Optional single-step mode via `define STEP_MODE_EN (adds the step input and a WAIT state).
module control_sequencer #(
    parameter int              OPW    = 5,
    parameter logic [OPW-1:0]  ADD_OP = OPW'(3)
) (
    input  logic            Clock,
    input  logic            clr,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
`ifdef STEP_MODE_EN
    input  logic            step,
`endif
    output logic            PC_out, ZHigh_out, ZLow_out,
    output logic            HI_out, LO_out, C_out,
    output logic            MDR_out, in_port_out,
    output logic            BA_out, R_out,
    output logic            MAR_enable, Z_enable,
    output logic            Y_enable, PC_enable,
    output logic            MDR_enable, IR_enable,
    output logic            LO_enable, HI_enable, R_in,
    output logic            Gra, Grb, Grc,
    output logic            IncPC, Read, RAM_write_enable,
    output logic            con_in, out_port_enable,
    output logic [OPW-1:0]  opcode,
    output logic            Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_WAIT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_t;

`ifdef STEP_MODE_EN
    localparam state_t S_END = S_WAIT;
`else
    localparam state_t S_END = S_T0;
`endif

    state_t          state_reg, state_next;
    cls_t            cls_reg;
    logic [OPW-1:0]  op_reg;
    logic            unused_ir_bits;

    assign unused_ir_bits = ^IR[26:0];

    function automatic cls_t decode(input logic [4:0] f);
        cls_t c;
        c = C_NOP;
        if (f >= 5'd3 && f <= 5'd11)       c = C_ALU;
        else if (f >= 5'd12 && f <= 5'd14) c = C_IMM;
        else begin
            case (f)
                5'd0:         c = C_LD;
                5'd1:         c = C_LDI;
                5'd2:         c = C_ST;
                5'd15, 5'd16: c = C_MULDIV;
                5'd17, 5'd18: c = C_UNARY;
                5'd19:        c = C_BR;
                5'd20:        c = C_JR;
                5'd21:        c = C_JAL;
                5'd22:        c = C_IN;
                5'd23:        c = C_OUT;
                5'd24:        c = C_MFHI;
                5'd25:        c = C_MFLO;
                5'd27:        c = C_HALT;
                default:      c = C_NOP;
            endcase
        end
        return c;
    endfunction

    // Final execute step of each class; anything reaching T7 is always the last step.
    function automatic logic is_last(input state_t s, input cls_t c);
        case (s)
            S_T3:    return c inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO};
            S_T4:    return c inside {C_UNARY, C_JAL};
            S_T5:    return c inside {C_ALU, C_IMM, C_LDI};
            S_T6:    return c inside {C_MULDIV, C_BR};
            default: return 1'b1;
        endcase
    endfunction

    always_ff @(posedge Clock) begin
        if (clr) begin
            state_reg <= S_RST;
            cls_reg   <= C_NOP;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_T2) begin
                cls_reg <= decode(IR[31:27]);
                op_reg  <= IR[31 -: OPW];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RST:  state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2: begin
                case (decode(IR[31:27]))
                    C_NOP:   state_next = S_END;
                    C_HALT:  state_next = S_HALT;
                    default: state_next = S_T3;
                endcase
            end
            S_T3:   state_next = is_last(state_reg, cls_reg) ? S_END : S_T4;
            S_T4:   state_next = is_last(state_reg, cls_reg) ? S_END : S_T5;
            S_T5:   state_next = is_last(state_reg, cls_reg) ? S_END : S_T6;
            S_T6:   state_next = is_last(state_reg, cls_reg) ? S_END : S_T7;
            S_T7:   state_next = S_END;
            S_HALT: state_next = S_HALT;
`ifdef STEP_MODE_EN
            S_WAIT: state_next = step ? S_T0 : S_WAIT;
`else
            S_WAIT: state_next = S_T0;
`endif
            default: state_next = S_RST;
        endcase
    end

    always_comb begin
        PC_out = 1'b0; ZHigh_out = 1'b0; ZLow_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
        C_out = 1'b0; MDR_out = 1'b0; in_port_out = 1'b0; BA_out = 1'b0; R_out = 1'b0;
        MAR_enable = 1'b0; Z_enable = 1'b0; Y_enable = 1'b0; PC_enable = 1'b0;
        MDR_enable = 1'b0; IR_enable = 1'b0; LO_enable = 1'b0; HI_enable = 1'b0; R_in = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; IncPC = 1'b0; Read = 1'b0; RAM_write_enable = 1'b0;
        con_in = 1'b0; out_port_enable = 1'b0; opcode = '0;
        Run = (state_reg != S_HALT);
        case (state_reg)
            S_T0: begin PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1; end
            S_T1: begin Read = 1'b1; MDR_enable = 1'b1; end
            S_T2: begin MDR_out = 1'b1; IR_enable = 1'b1; end
            S_T3: begin
                case (cls_reg)
                    C_ALU, C_IMM, C_MULDIV: begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    C_UNARY: begin Grb = 1'b1; R_out = 1'b1; opcode = op_reg; Z_enable = 1'b1; end
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1; end
                    C_BR:    begin Gra = 1'b1; R_out = 1'b1; con_in = 1'b1; end
                    C_JR:    begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    C_JAL:   begin PC_out = 1'b1; Grb = 1'b1; R_in = 1'b1; end
                    C_IN:    begin in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    C_OUT:   begin Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1; end
                    C_MFHI:  begin HI_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    C_MFLO:  begin LO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls_reg)
                    C_ALU, C_MULDIV: begin Grc = 1'b1; R_out = 1'b1; opcode = op_reg; Z_enable = 1'b1; end
                    C_IMM:   begin C_out = 1'b1; opcode = op_reg; Z_enable = 1'b1; end
                    C_UNARY: begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    C_LD, C_LDI, C_ST: begin C_out = 1'b1; opcode = ADD_OP; Z_enable = 1'b1; end
                    C_BR:    begin PC_out = 1'b1; Y_enable = 1'b1; end
                    C_JAL:   begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls_reg)
                    C_ALU, C_IMM, C_LDI: begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    C_MULDIV: begin ZLow_out = 1'b1; LO_enable = 1'b1; end
                    C_LD, C_ST: begin ZLow_out = 1'b1; MAR_enable = 1'b1; end
                    C_BR:     begin C_out = 1'b1; opcode = ADD_OP; Z_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls_reg)
                    C_MULDIV: begin ZHigh_out = 1'b1; HI_enable = 1'b1; end
                    C_LD:     begin Read = 1'b1; MDR_enable = 1'b1; end
                    C_ST:     begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
                    C_BR:     begin ZLow_out = 1'b1; PC_enable = CON_FF; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls_reg)
                    C_LD:    begin MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    C_ST:    RAM_write_enable = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
